// File: rtl/amiga_bus_decode_if.sv
// CPU-side bus bundle for amiga_bus_decode: address/strobe inputs, per-region
// attribute straps, and the active-low select and termination outputs.
interface amiga_bus_decode_if #(
  parameter int DEC_BITS = 3,
  parameter int WAIT_W   = 4
);
  localparam int NREG = 2 ** DEC_BITS;

  logic [DEC_BITS-1:0]    A;
  logic                   _AS;
  logic                   _DBR;
  logic                   _OVR;
  logic                   OVL;
  logic                   XRDY;
  logic [NREG-1:0]        REGION_EN;
  logic [NREG*WAIT_W-1:0] REGION_WAIT;
  logic [NREG-1:0]        REGION_CHIP;
  logic [NREG-1:0]        REGION_EXT;
  logic [NREG-1:0]        REGION_VPA;

  logic [NREG-1:0]        _SEL;
  logic                   _DTACK;
  logic                   _VPA;
  logic                   _BERR;
  logic                   _BLS;

  modport master (
    output A, _AS, _DBR, _OVR, OVL, XRDY,
    output REGION_EN, REGION_WAIT, REGION_CHIP, REGION_EXT, REGION_VPA,
    input  _SEL, _DTACK, _VPA, _BERR, _BLS
  );

  modport slave (
    input  A, _AS, _DBR, _OVR, OVL, XRDY,
    input  REGION_EN, REGION_WAIT, REGION_CHIP, REGION_EXT, REGION_VPA,
    output _SEL, _DTACK, _VPA, _BERR, _BLS
  );
endinterface

// File: rtl/amiga_bus_decode.sv
// amiga_bus_decode: clocked 68000 bus-cycle decoder. Maps the top address
// bits to one of NREG regions (with ROM overlay remap of region 0), inserts
// per-region wait states, stalls chip-bus regions during DMA, and terminates
// each cycle with _DTACK, _VPA or _BERR. A watchdog turns a WAIT that never
// completes into a bus error. All outputs are registered.
module amiga_bus_decode #(
  parameter int DEC_BITS = 3,
  parameter int WAIT_W   = 4,
  parameter int ROM_REG  = 7,
  parameter int TIMEOUT  = 64
) (
  input logic               C7M,
  input logic               _RESET,
  amiga_bus_decode_if.slave bus
);
  localparam int NREG = 2 ** DEC_BITS;
  localparam int TO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_VPA, S_BERR} state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wcnt_q;
  logic [TO_W-1:0]     tcnt_q;
  logic                chip_q;
  logic                ext_q;
  logic [NREG-1:0]     sel_q;
  logic                dtack_q;
  logic                vpa_q;
  logic                berr_q;
  logic                bls_q;

  logic                as_s;
  logic                dbr_s;
  logic                stall;
  logic [DEC_BITS-1:0] r_d;
  logic                en_d;
  logic                chip_d;
  logic                ext_d;
  logic                vpa_d;
  logic [WAIT_W-1:0]   wait_d;

  // Active-low one-hot select for region r.
  function automatic logic [NREG-1:0] sel_onehot_n(input logic [DEC_BITS-1:0] r);
    return ~(NREG'(1) << r);
  endfunction

  assign as_s  = ~bus._AS;
  assign dbr_s = ~bus._DBR;
  // Chip-bus regions freeze their wait count while DMA owns the bus.
  assign stall = chip_q & dbr_s;

  // Region index after overlay remap, and that region's attribute straps.
  always_comb begin
    r_d = bus.A;
    if (bus.OVL && (bus.A == '0)) r_d = DEC_BITS'(ROM_REG);
    en_d   = bus.REGION_EN[r_d];
    chip_d = bus.REGION_CHIP[r_d];
    ext_d  = bus.REGION_EXT[r_d];
    vpa_d  = bus.REGION_VPA[r_d];
    wait_d = bus.REGION_WAIT[r_d*WAIT_W +: WAIT_W];
  end

  // Bus-cycle FSM with registered select and termination outputs.
  always_ff @(posedge C7M or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      chip_q  <= 1'b0;
      ext_q   <= 1'b0;
      sel_q   <= '1;
      dtack_q <= 1'b1;
      vpa_q   <= 1'b1;
      berr_q  <= 1'b1;
      bls_q   <= 1'b1;
    end else if ((state_q != S_IDLE) && !as_s) begin
      // Strobe gone: end (or abort) the cycle and release everything.
      state_q <= S_IDLE;
      sel_q   <= '1;
      dtack_q <= 1'b1;
      vpa_q   <= 1'b1;
      berr_q  <= 1'b1;
      bls_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (as_s && bus._OVR) begin
            chip_q <= chip_d;
            ext_q  <= ext_d;
            wcnt_q <= wait_d;
            tcnt_q <= '0;
            if (!en_d) begin
              state_q <= S_BERR;
              berr_q  <= 1'b0;
            end else if (vpa_d) begin
              state_q <= S_VPA;
              vpa_q   <= 1'b0;
              sel_q   <= sel_onehot_n(r_d);
            end else begin
              state_q <= S_WAIT;
              sel_q   <= sel_onehot_n(r_d);
              bls_q   <= ~chip_d;
            end
          end
        end
        S_WAIT: begin
          // Watchdog wins over a completion on the same edge.
          if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            state_q <= S_BERR;
            berr_q  <= 1'b0;
            sel_q   <= '1;
            bls_q   <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TO_W'(1);
            if (!stall) begin
              if (wcnt_q != '0) begin
                wcnt_q <= wcnt_q - WAIT_W'(1);
              end else if (!ext_q || bus.XRDY) begin
                state_q <= S_ACK;
                dtack_q <= 1'b0;
              end
            end
          end
        end
        S_ACK: begin
          // External-ready regions drop DTACK while XRDY is low, without leaving ACK.
          dtack_q <= ext_q & ~bus.XRDY;
        end
        S_VPA: begin
          vpa_q <= 1'b0;
        end
        S_BERR: begin
          berr_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= '1;
          dtack_q <= 1'b1;
          vpa_q   <= 1'b1;
          berr_q  <= 1'b1;
          bls_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus._SEL   = sel_q;
  assign bus._DTACK = dtack_q;
  assign bus._VPA   = vpa_q;
  assign bus._BERR  = berr_q;
  assign bus._BLS   = bls_q;
endmodule
